// File: rtl/nmr_bstrm_simp_capture.sv
// Run-length capture of a synchronized 1-bit bitstream into {polarity, length} records,
// drained through a first-word-fall-through FIFO with a valid/ready interface.
module nmr_bstrm_simp_capture #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        STOP,
  output logic                        DPATH_RDY,
  output logic                        DONE,
  input  logic                        BSTRM_IN,
  output logic [DATA_WIDTH-1:0]       DOUT,
  output logic                        DOUT_POL,
  output logic                        DOUT_VALID,
  input  logic                        DOUT_READY,
  output logic                        OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LVL
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [DATA_WIDTH-1:0] CntMax = {DATA_WIDTH{1'b1}};
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StArm   = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StFlush = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sin;
  logic                   pol_q, pol_d;
  logic [DATA_WIDTH-1:0]  cnt_q, cnt_d;
  logic                   push, push_ok, pop;
  logic                   ovf_q, ovf_d;
  logic                   dpath_rdy_q, done_q;
  logic [DATA_WIDTH:0]    mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0]    head;
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]        lvl_q, lvl_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], BSTRM_IN};
    end
  end

  assign sin = sync_q[SYNC_STAGES-1];

  // The pushed record is always {pol_q, cnt_q}; on saturation cnt_q already equals CntMax.
  always_comb begin
    state_d = state_q;
    pol_d   = pol_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    case (state_q)
      StIdle: begin
        if (START) state_d = StArm;
      end
      StArm: begin
        pol_d   = sin;
        cnt_d   = DATA_WIDTH'(1);
        state_d = StRun;
      end
      StRun: begin
        if (STOP) begin
          push    = 1'b1;
          state_d = StFlush;
        end else if (sin != pol_q) begin
          push  = 1'b1;
          pol_d = sin;
          cnt_d = DATA_WIDTH'(1);
        end else if (cnt_q == CntMax) begin
          push  = 1'b1;
          cnt_d = DATA_WIDTH'(1);
        end else begin
          cnt_d = cnt_q + DATA_WIDTH'(1);
        end
      end
      StFlush: begin
        if (lvl_q == '0) state_d = StDone;
      end
      StDone: begin
        if (!START) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    pop      = (lvl_q != '0) && DOUT_READY;
    push_ok  = push && ((lvl_q != LvlFull) || pop);
    wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    lvl_d    = lvl_q;
    if (push_ok && !pop) begin
      lvl_d = lvl_q + LvlW'(1);
    end else if (!push_ok && pop) begin
      lvl_d = lvl_q - LvlW'(1);
    end
    ovf_d = ovf_q;
    if ((state_q == StIdle) && START) ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      pol_q       <= 1'b0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lvl_q       <= '0;
      dpath_rdy_q <= 1'b0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      pol_q       <= pol_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lvl_q       <= lvl_d;
      dpath_rdy_q <= (state_d == StIdle);
      done_q      <= (state_d == StIdle) || (state_d == StDone);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= {pol_q, cnt_q};
  end

  assign head       = mem_q[rd_ptr_q];
  assign DOUT_VALID = (lvl_q != '0);
  assign DOUT       = DOUT_VALID ? head[DATA_WIDTH-1:0] : '0;
  assign DOUT_POL   = DOUT_VALID & head[DATA_WIDTH];
  assign FIFO_LVL   = lvl_q;
  assign OVERFLOW   = ovf_q;
  assign DPATH_RDY  = dpath_rdy_q;
  assign DONE       = done_q;

endmodule
